// File: rtl/ahb_master_if.sv
// Per-master AHB request front end: arbitrates for the bus and runs one
// single NONSEQ transfer per beat, returning one response per beat.
module ahb_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_len,
    input  logic [1:0]        cmd_sel,
    output logic              hreq,
    output logic [1:0]        sel,
    input  logic              hgrant,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ADDR, S_DATA} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam int         TMO_W         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state_q;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [4:0]          beats_q;
    logic [TMO_W-1:0]    tmo_q;

    logic                cmd_ready_q, hreq_q, hwrite_q, busy_q;
    logic [1:0]          sel_q, htrans_q;
    logic [ADDR_W-1:0]   haddr_q;
    logic [2:0]          hsize_q;
    logic [DATA_W-1:0]   hwdata_q, rsp_rdata_q;
    logic                rsp_valid_q, rsp_err_q, rsp_last_q;

    logic progress, tmo_abort, beat_err, beat_final, cmd_end;

    // Progress is any phase handshake; the timeout only fires when none happens.
    assign progress   = (state_q == S_REQ && hgrant) ||
                        ((state_q == S_ADDR || state_q == S_DATA) && hready);
    assign tmo_abort  = (TIMEOUT != 0) && (state_q != S_IDLE) && !progress &&
                        (tmo_q == TMO_LAST);
    assign beat_err   = (state_q == S_DATA) && hready && hresp;
    assign beat_final = (state_q == S_DATA) && hready && !hresp && (beats_q == 5'd1);
    assign cmd_end    = tmo_abort || beat_err || beat_final;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beats_q     <= '0;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b0;
            hreq_q      <= 1'b0;
            sel_q       <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        write_q     <= cmd_write;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        beats_q     <= {1'b0, cmd_len} + 5'd1;
                        tmo_q       <= '0;
                        sel_q       <= cmd_sel;
                        hreq_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (hgrant) begin
                        tmo_q    <= '0;
                        htrans_q <= HTRANS_NONSEQ;
                        haddr_q  <= addr_q;
                        hwrite_q <= write_q;
                        hsize_q  <= HSIZE_WORD;
                        state_q  <= S_ADDR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        tmo_q    <= '0;
                        htrans_q <= HTRANS_IDLE;
                        haddr_q  <= '0;
                        hwrite_q <= 1'b0;
                        hsize_q  <= '0;
                        hwdata_q <= write_q ? wdata_q : '0;
                        state_q  <= S_DATA;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (hready) begin
                        tmo_q       <= '0;
                        hwdata_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        if (!hresp) begin
                            if (!write_q) rsp_rdata_q <= hrdata;
                            beats_q <= beats_q - 5'd1;
                            addr_q  <= addr_q + ADDR_W'(4);
                            state_q <= S_REQ;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // NOTE: these non-blocking assignments come last, so they override the per-state ones above.
            if (cmd_end) begin
                state_q     <= S_IDLE;
                hreq_q      <= 1'b0;
                sel_q       <= '0;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
                htrans_q    <= HTRANS_IDLE;
                haddr_q     <= '0;
                hwrite_q    <= 1'b0;
                hsize_q     <= '0;
                hwdata_q    <= '0;
                rsp_valid_q <= 1'b1;
                rsp_last_q  <= 1'b1;
                rsp_err_q   <= tmo_abort || beat_err;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign hreq      = hreq_q;
    assign sel       = sel_q;
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: a reactive arbiter/slave plus a
// transaction-level scoreboard checked on every cycle.
module tb_ahb_master_if;

    localparam int TMO = 8;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_sel;
    logic        cmd_ready, hreq, hwrite, busy;
    logic [1:0]  sel, htrans;
    logic [31:0] haddr, hwdata, rsp_rdata;
    logic [2:0]  hsize;
    logic        rsp_valid, rsp_err, rsp_last;
    logic        hgrant = 1'b0;
    logic        hready = 1'b1;
    logic        hresp  = 1'b0;
    logic [31:0] hrdata = '0;

    always #5 hclk = ~hclk;

    ahb_master_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .hclk(hclk), .hreset(hreset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .hreq(hreq), .sel(sel), .hgrant(hgrant),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .busy(busy)
    );

    logic [109:0] all_outs;
    assign all_outs = {cmd_ready, hreq, sel, haddr, htrans, hwrite, hsize, hwdata,
                       rsp_valid, rsp_rdata, rsp_err, rsp_last, busy};

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Arbiter / slave behaviour knobs, set by the stimulus.
    int          grant_delay = 0;
    int          addr_waits  = 0;
    int          data_waits  = 0;
    int          err_beat    = -1;
    logic [31:0] rdata_base  = '0;

    typedef struct { logic [31:0] addr; logic write; } xfer_t;
    typedef struct { logic [31:0] rdata; logic err; logic last; logic rd; logic tmo; } rsp_t;

    xfer_t       exp_x[$];
    rsp_t        exp_r[$];
    logic [31:0] exp_wdata = '0;
    logic [1:0]  exp_sel   = '0;

    // Observation counters used by the literal expectations.
    int          cyc = 0, nonseq_cyc = 0, dphase_cyc = 0, rsp_cnt = 0;
    int          hreq_rise_cyc = 0, rsp_cyc = 0;
    logic [31:0] last_addr_obs = '0, last_rdata_obs = '0;

    // Reactive arbiter + slave: one-cycle grant per beat, scripted wait states.
    int r_gcnt = 0, r_awc = 0, r_dwc = 0, r_beat = 0;
    bit r_xfer = 0, r_dp = 0;
    always begin
        @(posedge hclk);
        #1;
        if (hreset) begin
            hgrant = 0; hready = 1; hresp = 0;
            r_gcnt = 0; r_awc = 0; r_dwc = 0; r_beat = 0; r_xfer = 0; r_dp = 0;
        end else begin
            hready = 1;
            hresp  = 0;
            if (!busy) begin
                r_beat = 0;
                r_gcnt = 0;
            end
            if (r_dp) begin
                if (r_dwc < data_waits) begin
                    hready = 0;
                    r_dwc++;
                end else begin
                    hrdata = rdata_base ^ 32'(r_beat);
                    hresp  = (r_beat == err_beat);
                    r_dp = 0; r_dwc = 0; r_beat++; r_xfer = 0; r_gcnt = 0;
                end
            end else if (htrans == 2'b10) begin
                hgrant = 0;
                if (r_awc < addr_waits) begin
                    hready = 0;
                    r_awc++;
                end else begin
                    r_awc = 0;
                    r_dp  = 1;
                end
            end else if (hreq && !r_xfer) begin
                if (r_gcnt >= grant_delay) begin
                    hgrant = 1;
                    r_xfer = 1;
                end else begin
                    r_gcnt++;
                end
            end
        end
    end

    // Compare process: invariants every cycle, scoreboard on every transfer and response.
    bit    m_dp = 0, m_wr = 0, pend = 0, prev_hreq = 0;
    int    rst_age = 0;
    xfer_t mx;
    rsp_t  mr;
    always @(negedge hclk) begin
        cyc++;
        if (hreset) begin
            m_dp = 0; pend = 0; prev_hreq = 0; rst_age = 0;
        end else begin
            rst_age++;
            check("htrans_legal", (htrans == 2'b00) || (htrans == 2'b10), 1'b1);
            check("hreq_vs_busy", hreq, busy);
            check("sel", sel, busy ? exp_sel : 2'b00);
            if (busy) check("cmd_ready_busy", cmd_ready, 1'b0);
            else if (rst_age > 1) check("cmd_ready_idle", cmd_ready, 1'b1);
            if (hreq && !prev_hreq) hreq_rise_cyc = cyc;
            prev_hreq = hreq;

            if (rsp_valid) begin
                rsp_cyc = cyc;
                rsp_cnt++;
                last_rdata_obs = rsp_rdata;
                if (exp_r.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    mr = exp_r.pop_front();
                    if (!mr.tmo) check("rsp_timing", pend, 1'b1);
                    check("rsp_err", rsp_err, mr.err);
                    check("rsp_last", rsp_last, mr.last);
                    if (mr.rd && !mr.err) check("rsp_rdata", rsp_rdata, mr.rdata);
                end
            end else if (pend) begin
                check("rsp_missing", 1'b0, 1'b1);
            end
            pend = 0;

            if (htrans == 2'b10) begin
                nonseq_cyc++;
                if (exp_x.size() == 0) begin
                    check("xfer_unexpected", 1'b1, 1'b0);
                end else begin
                    check("haddr", haddr, exp_x[0].addr);
                    check("hwrite", hwrite, exp_x[0].write);
                    check("hsize", hsize, 3'b010);
                    if (hready) begin
                        mx = exp_x.pop_front();
                        last_addr_obs = haddr;
                        m_dp = 1;
                        m_wr = mx.write;
                    end
                end
            end else if (m_dp) begin
                dphase_cyc++;
                if (m_wr) check("hwdata", hwdata, exp_wdata);
                if (hready) begin
                    m_dp = 0;
                    pend = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] len, input logic [1:0] s, input bit tmo);
        int k = 0;
        int nb;
        while (!cmd_ready && k < 50) begin
            tick(1);
            k++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 1'b0, 1'b1);
        exp_wdata = wd;
        exp_sel   = s;
        if (tmo) begin
            exp_r.push_back('{rdata: '0, err: 1'b1, last: 1'b1, rd: !w, tmo: 1'b1});
        end else begin
            nb = (err_beat >= 0 && err_beat <= int'(len)) ? err_beat + 1 : int'(len) + 1;
            for (int i = 0; i < nb; i++) begin
                exp_x.push_back('{addr: a + 32'(4 * i), write: w});
                exp_r.push_back('{rdata: rdata_base ^ 32'(i), err: (i == err_beat),
                                  last: (i == nb - 1), rd: !w, tmo: 1'b0});
            end
        end
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_len = len; cmd_sel = s;
        tick(1);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((exp_r.size() != 0 || busy) && k < budget) begin
            tick(1);
            k++;
        end
        check("cmd_completes", (exp_r.size() == 0) && !busy, 1'b1);
    endtask

    int n0, r0, d0;

    initial begin
        hreset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd_len = '0; cmd_sel = '0;
        #12;
        check("reset_outputs", all_outs, '0);
        #5 hreset = 0;
        tick(1);
        check("post_reset_ready", cmd_ready, 1'b1);
        check("post_reset_busy", busy, 1'b0);

        // Single read
        grant_delay = 2; addr_waits = 0; data_waits = 0; err_beat = -1; rdata_base = 32'hDEADBEEF;
        n0 = nonseq_cyc; r0 = rsp_cnt;
        issue(1'b0, 32'h100, 32'h0, 4'd0, 2'd2, 0);
        wait_done(100);
        check("rd_rdata_lit", last_rdata_obs, 32'hDEADBEEF);
        check("rd_addr_lit", last_addr_obs, 32'h100);
        check("rd_nonseq_cycles", nonseq_cyc - n0, 1);
        check("rd_rsp_count", rsp_cnt - r0, 1);
        check("rd_hreq_low", hreq, 1'b0);

        // Write fill, four beats
        grant_delay = 1;
        n0 = nonseq_cyc; r0 = rsp_cnt;
        issue(1'b1, 32'h200, 32'hA5A5A5A5, 4'd3, 2'd1, 0);
        wait_done(200);
        check("wr_last_addr_lit", last_addr_obs, 32'h20C);
        check("wr_nonseq_cycles", nonseq_cyc - n0, 4);
        check("wr_rsp_count", rsp_cnt - r0, 4);

        // Wait states in both phases, with a stray command while busy
        grant_delay = 0; addr_waits = 3; data_waits = 2;
        n0 = nonseq_cyc; r0 = rsp_cnt; d0 = dphase_cyc;
        issue(1'b1, 32'h400, 32'h12345678, 4'd0, 2'd0, 0);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h999; cmd_sel = 2'd3; cmd_len = 4'd5;
        tick(2);
        cmd_valid = 0;
        wait_done(100);
        check("ws_nonseq_cycles", nonseq_cyc - n0, 4);
        check("ws_dphase_cycles", dphase_cyc - d0, 3);
        check("ws_rsp_count", rsp_cnt - r0, 1);

        // Slave error on the second of three beats
        grant_delay = 1; addr_waits = 0; data_waits = 0; err_beat = 1; rdata_base = 32'h0BAD0000;
        n0 = nonseq_cyc; r0 = rsp_cnt;
        issue(1'b0, 32'h500, 32'h0, 4'd2, 2'd1, 0);
        wait_done(100);
        check("err_nonseq_cycles", nonseq_cyc - n0, 2);
        check("err_rsp_count", rsp_cnt - r0, 2);
        check("err_last_addr_lit", last_addr_obs, 32'h504);
        tick(1);
        check("err_back_idle", cmd_ready, 1'b1);
        err_beat = -1;

        // Timeout while never granted
        grant_delay = 1000;
        n0 = nonseq_cyc; r0 = rsp_cnt;
        issue(1'b0, 32'h600, 32'h0, 4'd2, 2'd3, 1);
        wait_done(100);
        check("tmo_latency", rsp_cyc - hreq_rise_cyc, TMO);
        check("tmo_rsp_count", rsp_cnt - r0, 1);
        check("tmo_no_xfer", nonseq_cyc - n0, 0);
        check("tmo_bus_idle", {hreq, sel, htrans, haddr, hwrite, hsize, hwdata}, '0);

        // Reset during the data phase of a read
        grant_delay = 0; data_waits = 5; rdata_base = 32'h11223344;
        issue(1'b0, 32'h700, 32'h0, 4'd0, 2'd2, 0);
        tick(3);
        #2 hreset = 1;
        #1;
        check("mid_reset_outputs", all_outs, '0);
        exp_x.delete();
        exp_r.delete();
        r0 = rsp_cnt;
        tick(2);
        #2 hreset = 0;
        tick(3);
        check("mid_reset_no_rsp", rsp_cnt - r0, 0);
        check("mid_reset_ready", cmd_ready, 1'b1);

        // Address wrap across the top of the address space
        grant_delay = 1; data_waits = 0; rdata_base = 32'hCAFE0000;
        r0 = rsp_cnt;
        issue(1'b0, 32'hFFFFFFFC, 32'h0, 4'd1, 2'd0, 0);
        wait_done(100);
        check("wrap_addr_lit", last_addr_obs, 32'h00000000);
        check("wrap_rdata_lit", last_rdata_obs, 32'hCAFE0001);
        check("wrap_rsp_count", rsp_cnt - r0, 2);

        tick(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/ahb_master_if.md
Name: ahb_master_if

Overview:
- Per-master bus-request front end that sits directly upstream of the 3-master arbiter; one instance per master port.
- Accepts a local command (single read/write, or a multi-beat fill/read sequence).
- Drives the arbiter request and slave-select lines, waits for grant, then runs AHB address and data phases.
- Returns read data and error status per beat.
- Each beat is a separately arbitrated single NONSEQ transfer, because the arbiter releases grant after every completed transfer.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 64, max cycles without progress in REQ/ADDR/DATA before abort; 0 disables the timeout.

Ports:
- hclk  in  1  bus clock.
- hreset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  start byte address, word aligned.
- cmd_wdata  in  DATA_W  write word, written to every beat of the sequence (fill).
- cmd_len  in  4  beats minus 1 (1..16 beats).
- cmd_sel  in  2  target slave select.
- hreq  out  1  bus request to arbiter.
- sel  out  2  slave select to arbiter.
- hgrant  in  1  grant from arbiter.
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  AHB transfer type; only IDLE 2'b00 and NONSEQ 2'b10 are used.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size.
- hwdata  out  DATA_W  AHB write data.
- hrdata  in  DATA_W  AHB read data.
- hready  in  1  ready from selected slave.
- hresp  in  1  0 = OKAY, 1 = ERROR.
- rsp_valid  out  1  one-cycle pulse per completed or aborted beat.
- rsp_rdata  out  DATA_W  read data; held until the next rsp_valid.
- rsp_err  out  1  valid with rsp_valid: slave error or timeout.
- rsp_last  out  1  valid with rsp_valid: final response of the command.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - All outputs go to 0 immediately, asynchronously, including hsize, rsp_rdata and the internal counters.
  - State returns to IDLE.
  - Reset mid-transfer drops hreq and htrans at once; no response is issued for the aborted command.
- States: IDLE, REQ, ADDR, DATA.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch write/addr/wdata/sel and set beats_left=cmd_len+1.
  - Next state REQ; hreq=1 and sel=latched sel from the next cycle.
- REQ:
  - hreq=1; remains in REQ until hgrant is sampled high.
  - Then go to ADDR.
- ADDR (address phase):
  - htrans=NONSEQ, haddr=cur_addr, hwrite=latched write, hsize=3'b010.
  - Advance to DATA on the first edge with hready=1.
- DATA:
  - htrans=IDLE; hwdata=latched wdata for writes, stable for the whole phase.
  - Wait for hready=1.
  - With hresp=0: pulse rsp_valid; capture hrdata into rsp_rdata on reads; decrement beats_left.
  - If beats_left reaches 0: rsp_last=1, hreq drops, go to IDLE.
  - Otherwise: cur_addr+=4, go to REQ (hreq stays high, re-arbitrated per beat).
  - With hresp=1 and hready=1: rsp_valid=1, rsp_err=1, rsp_last=1; remaining beats are discarded; go to IDLE.
- hreq is held high continuously from REQ entry until the command's last beat completes.
- The arbiter clears grant one cycle after completion; REQ must tolerate hgrant=0 for any number of cycles.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0. There is no 1 KB boundary handling.
- Timeout:
  - Counter clears on every state change and counts cycles spent in REQ/ADDR/DATA.
  - On reaching TIMEOUT: rsp_valid/rsp_err/rsp_last=1, all bus outputs return to 0, go to IDLE.
- Best-case latency per beat: REQ→ADDR 1 cycle after grant seen, ADDR 1 cycle, DATA 1 cycle.
- cmd_valid outside IDLE is ignored; the command is not latched.
- hgrant deasserting during ADDR or DATA is ignored; the phase completes.

Test Plan:
- Single read: cmd_addr=0x100, cmd_len=0, cmd_sel=2; grant after 2 cycles; slave returns 0xDEADBEEF with hready=1 → haddr=0x100 with NONSEQ for one cycle; rsp_valid once with rsp_rdata=0xDEADBEEF, rsp_last=1, rsp_err=0; hreq low after completion.
- Write fill, cmd_len=3, addr 0x200, wdata 0xA5A5A5A5; arbiter re-grants each beat → four NONSEQ transfers at 0x200/0x204/0x208/0x20C, each with hwdata=0xA5A5A5A5; four rsp_valid pulses with rsp_last only on the 4th.
- Wait states: hready low for 3 cycles in ADDR and 2 cycles in DATA → haddr and hwdata held stable; exactly one rsp_valid.
- Error mid-burst: cmd_len=2, hresp=1 on beat 2 → rsp_valid with rsp_err=1 and rsp_last=1 on beat 2; no 3rd address phase; back in IDLE with cmd_ready=1.
- Timeout: TIMEOUT=8, hgrant held 0 → rsp_err pulse exactly 8 cycles after REQ entry; hreq=0 afterwards.
- Reset during DATA of a read, plus address wrap: assert hreset → all outputs 0 in the same cycle; after release, cmd_addr=0xFFFFFFFC with cmd_len=1 → second beat haddr=0x00000000.
